knn_distance_engine: RTL and testbench

Multi-lane, multi-metric successor to the KNN distance calculator. It computes the distance between one M×N training sample and one M×N input sample, consuming P element pairs per clock. The metric is selectable per job: Manhattan or squared Euclidean. The accumulator saturates and reports overflow. It sits between the training-sample memory and the KNN sorter, forwarding each sample's class label alongside its distance.

---
 rtl/knn_distance_engine_if.sv | 38 +++
 rtl/knn_distance_engine.sv | 135 +++++++++++++
 tb/tb_knn_distance_engine.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_distance_engine_if.sv
// ============================================================================
// Module      : knn_distance_engine_if
// Description : Job request / result bundle between the sample source, the
//               distance engine and the KNN sorter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface knn_distance_engine_if #(
    parameter int M  = 5,
    parameter int N  = 10,
    parameter int W  = 16,
    parameter int DW = 32,
    parameter int TW = 4
);
    logic                 start;
    logic                 mode;
    logic [M*N*W-1:0]     training_data;
    logic [TW-1:0]        training_data_type;
    logic [M*N*W-1:0]     input_data;
    logic [DW-1:0]        distance;
    logic [TW-1:0]        data_type;
    logic                 sat;
    logic                 busy;
    logic                 done;

    modport master (
        output start, mode, training_data, training_data_type, input_data,
        input  distance, data_type, sat, busy, done
    );

    modport slave (
        input  start, mode, training_data, training_data_type, input_data,
        output distance, data_type, sat, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/knn_distance_engine.sv
// ============================================================================
// Module      : knn_distance_engine
// Description : P-lane Manhattan / squared-Euclidean distance between two
//               MxN samples, with saturating accumulator and label forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module knn_distance_engine #(
    parameter int M  = 5,
    parameter int N  = 10,
    parameter int W  = 16,
    parameter int P  = 4,
    parameter int DW = 32,
    parameter int TW = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    knn_distance_engine_if.slave bus
);

    localparam int NE = M * N;
    localparam int C  = (NE + P - 1) / P;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    // Wide enough for the running total plus one full cycle of squared terms
    localparam int SW = DW + 2 * W + $clog2(P + 1) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(C - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_acc;
    logic            r_ovf;
    logic            r_mode;
    logic [TW-1:0]   r_label;
    logic [DW-1:0]   r_distance;
    logic [TW-1:0]   r_data_type;
    logic            r_sat;
    logic            r_busy;
    logic            r_done;

    int              w_k;
    logic [W-1:0]    w_t;
    logic [W-1:0]    w_x;
    logic [W-1:0]    w_diff;
    logic [2*W-1:0]  w_term;
    logic [SW-1:0]   w_lane_sum;
    logic [SW-1:0]   w_full;
    logic            w_ovf;
    logic [DW-1:0]   w_acc_next;

    always_comb begin
        w_k        = 0;
        w_t        = '0;
        w_x        = '0;
        w_diff     = '0;
        w_term     = '0;
        w_lane_sum = '0;
        for (int l = 0; l < P; l++) begin
            w_k = int'(r_cnt) * P + l;
            // Lanes past the last element are padding and add nothing
            if (w_k < NE) begin
                w_t        = bus.training_data[w_k*W +: W];
                w_x        = bus.input_data[w_k*W +: W];
                w_diff     = (w_t >= w_x) ? (w_t - w_x) : (w_x - w_t);
                w_term     = r_mode ? ({{W{1'b0}}, w_diff} * {{W{1'b0}}, w_diff})
                                    : {{W{1'b0}}, w_diff};
                w_lane_sum = w_lane_sum + SW'(w_term);
            end
        end
        w_full     = SW'(r_acc) + w_lane_sum;
        w_ovf      = (w_full > SW'({DW{1'b1}}));
        w_acc_next = w_ovf ? {DW{1'b1}} : w_full[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_mode      <= 1'b0;
            r_label     <= '0;
            r_distance  <= '0;
            r_data_type <= '0;
            r_sat       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mode  <= bus.mode;
                        r_label <= bus.training_data_type;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    r_acc <= w_acc_next;
                    r_ovf <= r_ovf | w_ovf;
                    if (r_cnt == C_LAST) begin
                        r_distance  <= w_acc_next;
                        r_data_type <= r_label;
                        r_sat       <= r_ovf | w_ovf;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.distance  = r_distance;
    assign bus.data_type = r_data_type;
    assign bus.sat       = r_sat;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_knn_distance_engine.sv
// ============================================================================
// Module      : tb_knn_distance_engine
// Description : Self-checking bench for knn_distance_engine with a whole-sample
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_knn_distance_engine;

    localparam int M  = 5;
    localparam int N  = 10;
    localparam int W  = 16;
    localparam int P  = 4;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int NE = M * N;
    localparam int VW = M * N * W;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    knn_distance_engine_if #(.M(M), .N(N), .W(W), .DW(DW), .TW(TW)) bus ();

    knn_distance_engine #(.M(M), .N(N), .W(W), .P(P), .DW(DW), .TW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] fill(input int unsigned v);
        logic [VW-1:0] r;
        for (int k = 0; k < NE; k++) r[k*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec(input int unsigned mask);
        logic [VW-1:0] r;
        for (int k = 0; k < NE; k++) r[k*W +: W] = W'($urandom & mask);
        return r;
    endfunction

    // Whole-sample distance with a single final clamp (terms are never negative)
    task automatic ref_model(input logic [VW-1:0] t, input logic [VW-1:0] x,
                             input logic m, output logic [DW-1:0] d, output logic s);
        longint unsigned tot;
        longint unsigned a;
        longint unsigned b;
        longint unsigned df;
        tot = 0;
        for (int k = 0; k < NE; k++) begin
            a   = longint'(t[k*W +: W]);
            b   = longint'(x[k*W +: W]);
            df  = (a > b) ? a - b : b - a;
            tot = tot + (m ? df * df : df);
        end
        s = (tot > 64'hFFFF_FFFF);
        d = s ? 32'hFFFF_FFFF : tot[31:0];
    endtask

    task automatic run_job(input logic [VW-1:0] t, input logic [VW-1:0] x,
                           input logic m, input logic [TW-1:0] lbl,
                           output logic [DW-1:0] d, output logic [TW-1:0] ty,
                           output logic s, output int lat, output int bcnt,
                           output logic done_again);
        @(negedge clk);
        bus.training_data      = t;
        bus.input_data         = x;
        bus.mode               = m;
        bus.training_data_type = lbl;
        bus.start              = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int n = 1; n <= 100; n++) begin
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = n - 1;
                break;
            end
            @(negedge clk);
        end
        d  = bus.distance;
        ty = bus.data_type;
        s  = bus.sat;
        @(negedge clk);
        done_again = bus.done;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.training_data      = '0;
        bus.input_data         = '0;
        bus.training_data_type = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.distance, bus.data_type, bus.sat, bus.busy, bus.done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got dist=%0h type=%0h sat=%b busy=%b done=%b want all 0",
                     bus.distance, bus.data_type, bus.sat, bus.busy, bus.done);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_manhattan_ones();
        logic [DW-1:0] d; logic [TW-1:0] ty; logic s, dw; int lat, bc;
        run_job(fill(1), fill(0), 1'b0, 4'd5, d, ty, s, lat, bc, dw);
        total++; if (d !== 32'd50) begin bad++; $display("FAIL ones_distance: got %0d want 50", d); end
        total++; if (ty !== 4'd5) begin bad++; $display("FAIL ones_label: got %0d want 5", ty); end
        total++; if (s !== 1'b0) begin bad++; $display("FAIL ones_sat: got %b want 0", s); end
        total++; if (lat != 13) begin bad++; $display("FAIL ones_latency: got %0d want 13", lat); end
        total++; if (bc != 13) begin bad++; $display("FAIL ones_busy_cycles: got %0d want 13", bc); end
        total++; if (dw !== 1'b0) begin bad++; $display("FAIL ones_done_width: got done=%b in next cycle want 0", dw); end
    endtask

    task automatic test_metrics();
        logic [DW-1:0] d; logic [TW-1:0] ty; logic s, dw; int lat, bc;
        run_job(fill(3), fill(10), 1'b0, 4'd2, d, ty, s, lat, bc, dw);
        total++; if (d !== 32'd350) begin bad++; $display("FAIL absdiff_manhattan: got %0d want 350", d); end
        run_job(fill(3), fill(10), 1'b1, 4'd2, d, ty, s, lat, bc, dw);
        total++; if (d !== 32'd2450) begin bad++; $display("FAIL absdiff_squared: got %0d want 2450", d); end
    endtask

    task automatic test_padded();
        logic [DW-1:0] d; logic [TW-1:0] ty; logic s, dw; int lat, bc;
        logic [VW-1:0] t, x;
        t = '0; x = '0;
        t[(4*N+8)*W +: W] = 16'd7;
        x[(4*N+9)*W +: W] = 16'd9;
        run_job(t, x, 1'b1, 4'd1, d, ty, s, lat, bc, dw);
        total++; if (d !== 32'd130) begin bad++; $display("FAIL padded_lanes: got %0d want 130", d); end
        total++; if (s !== 1'b0) begin bad++; $display("FAIL padded_sat: got %b want 0", s); end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] d; logic [TW-1:0] ty; logic s, dw; int lat, bc;
        run_job(fill(16'hFFFF), fill(0), 1'b1, 4'd7, d, ty, s, lat, bc, dw);
        total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_distance: got %0h want ffffffff", d); end
        total++; if (s !== 1'b1) begin bad++; $display("FAIL sat_flag: got %b want 1", s); end
        run_job(fill(1), fill(0), 1'b0, 4'd7, d, ty, s, lat, bc, dw);
        total++; if (d !== 32'd50) begin bad++; $display("FAIL sat_clear_distance: got %0d want 50", d); end
        total++; if (s !== 1'b0) begin bad++; $display("FAIL sat_clear_flag: got %b want 0", s); end
    endtask

    task automatic test_ignored_start();
        int e, extra;
        @(negedge clk);
        bus.training_data      = fill(1);
        bus.input_data         = fill(0);
        bus.mode               = 1'b0;
        bus.training_data_type = 4'd3;
        bus.start              = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start              = 1'b1;
        bus.training_data_type = 4'd9;
        bus.mode               = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        e = 5;
        while (!bus.done && e < 100) begin
            @(negedge clk);
            e++;
        end
        total++; if (e != 13) begin bad++; $display("FAIL ignored_start_latency: got edge %0d want 13", e); end
        total++; if (bus.data_type !== 4'd3) begin bad++; $display("FAIL ignored_start_label: got %0d want 3", bus.data_type); end
        total++; if (bus.distance !== 32'd50) begin bad++; $display("FAIL ignored_mode_change: got %0d want 50", bus.distance); end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL ignored_start_no_queue: got %0d busy/done cycles want 0", extra); end
        bus.mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        int q[$];
        int guard;
        @(negedge clk);
        bus.training_data      = fill(1);
        bus.input_data         = fill(0);
        bus.mode               = 1'b0;
        bus.training_data_type = 4'd6;
        bus.start              = 1'b1;
        @(posedge clk);
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            if (bus.done) q.push_back(e);
        end
        bus.start = 1'b0;
        guard = 0;
        while (bus.busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (q.size() != 2 || q[0] != 13 || q[1] != 27) begin
            bad++;
            $display("FAIL back_to_back_done_edges: got %0d pulses (first=%0d second=%0d) want edges 13 and 27",
                     q.size(), (q.size() > 0) ? q[0] : -1, (q.size() > 1) ? q[1] : -1);
        end
        total++; if (bus.data_type !== 4'd6) begin bad++; $display("FAIL back_to_back_label: got %0d want 6", bus.data_type); end
    endtask

    task automatic test_midjob_reset();
        logic [DW-1:0] d, rd; logic [TW-1:0] ty; logic s, rs, dw; int lat, bc, dn;
        logic [VW-1:0] t, x;
        @(negedge clk);
        bus.training_data      = fill(2);
        bus.input_data         = fill(0);
        bus.training_data_type = 4'd4;
        bus.start              = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({bus.distance, bus.data_type, bus.sat, bus.busy, bus.done} !== '0) begin
            bad++;
            $display("FAIL midjob_reset_outputs: got dist=%0h type=%0h sat=%b busy=%b done=%b want all 0",
                     bus.distance, bus.data_type, bus.sat, bus.busy, bus.done);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        total++; if (dn != 0) begin bad++; $display("FAIL midjob_reset_no_done: got %0d pulses want 0", dn); end
        t = rand_vec(32'hFF);
        x = rand_vec(32'hFF);
        ref_model(t, x, 1'b1, rd, rs);
        run_job(t, x, 1'b1, 4'd11, d, ty, s, lat, bc, dw);
        total++; if (lat != 13) begin bad++; $display("FAIL post_reset_latency: got %0d want 13", lat); end
        total++; if (d !== rd) begin bad++; $display("FAIL post_reset_distance: got %0d want %0d", d, rd); end
    endtask

    task automatic test_random();
        logic [DW-1:0] d, rd; logic [TW-1:0] ty, lbl; logic s, rs, dw, m; int lat, bc;
        logic [VW-1:0] t, x;
        int unsigned mask;
        for (int i = 0; i < 10; i++) begin
            mask = 32'hFFFF >> $urandom_range(0, 12);
            t    = rand_vec(mask);
            x    = rand_vec(mask);
            m    = 1'($urandom);
            lbl  = TW'($urandom);
            ref_model(t, x, m, rd, rs);
            run_job(t, x, m, lbl, d, ty, s, lat, bc, dw);
            total++;
            if (d !== rd || s !== rs || ty !== lbl || lat != 13) begin
                bad++;
                $display("FAIL random_job%0d: got dist=%0h sat=%b type=%0d lat=%0d want dist=%0h sat=%b type=%0d lat=13",
                         i, d, s, ty, lat, rd, rs, lbl);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_manhattan_ones();
        test_metrics();
        test_padded();
        test_saturation();
        test_ignored_start();
        test_back_to_back();
        test_midjob_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
